// File: rtl/rsdec_pkg.sv
// ---------------------------------------------------------------------------
// rsdec_pkg
// Shared definitions for the Reed-Solomon decoder Berlekamp-Massey control
// slice:
//   - state_t   : FSM state encoding of rsdec_berl_ctrl
//   - NSYN_DEF  : default syndrome count (2t) / number of BM iterations
//   - NPH_DEF   : default cycles per BM iteration (1 discrepancy + 32 shift)
//   - GF_POLY   : GF(256) field polynomial x^8+x^4+x^3+x^2+1 (0x11D)
//   - gf_mul    : GF(256) multiply reduced by GF_POLY
// ---------------------------------------------------------------------------
package rsdec_pkg;

    localparam int NSYN_DEF = 32;
    localparam int NPH_DEF  = 33;

    localparam logic [8:0] GF_POLY = 9'h11D;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        CALC,
        DRAIN,
        FIN
    } state_t;

    // Shift-and-add multiply; the running multiplicand is reduced each time
    // it overflows bit 7, so the accumulator never leaves the field.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ x;
            end
            x = x[7] ? ((x << 1) ^ GF_POLY[7:0]) : (x << 1);
        end
        return acc;
    endfunction

endpackage

// File: rtl/rsdec_gf256_inv.sv
// ---------------------------------------------------------------------------
// rsdec_gf256_inv
// Combinational GF(256) inverse lookup (field polynomial 0x11D).
// Ports:
//   d  [7:0] in  : field element
//   di [7:0] out : multiplicative inverse of d; inverse of 0 is defined as 0
// ---------------------------------------------------------------------------
module rsdec_gf256_inv
    import rsdec_pkg::*;
(
    input  logic [7:0] d,
    output logic [7:0] di
);

    // In GF(256) every nonzero a satisfies a^255 = 1, so a^-1 = a^254.
    // a^254 = a^2 * a^4 * ... * a^128, built by repeated squaring. For a = 0
    // the product is 0, which gives the required inv(0) = 0 for free.
    function automatic logic [7:0] gf_pow254(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Every entry is a constant expression, so the table folds to a ROM.
    logic [7:0] lut [256];

    for (genvar i = 0; i < 256; i++) begin : g_lut
        assign lut[i] = gf_pow254(8'(i));
    end

    assign di = lut[d];

endmodule

// File: rtl/rsdec_berl_ctrl.sv
// ---------------------------------------------------------------------------
// rsdec_berl_ctrl
// Sequencing controller for the Berlekamp-Massey key-equation datapath of the
// RS decoder. One start runs INIT (datapath load), NSYN iterations of NPH
// cycles each (CALC), an NSYN-cycle coefficient read-out (DRAIN) and a final
// FIN cycle, after which a one-cycle done pulse is issued.
//
// Optional feature (compile-time macro):
//   RSDEC_BERL_CTRL_ZERO_SKIP_EN : a start with syn_zero=1 skips straight to
//                                  FIN (no datapath activity, no out_valid).
//                                  Without it syn_zero is ignored.
//
// Ports:
//   clk         in      : clock, all state on rising edge
//   rst_n       in      : asynchronous active-low reset
//   start       in      : one-cycle decode request (ignored while busy)
//   syn_zero    in      : all syndromes zero, sampled with start
//   abort       in      : synchronous cancel, returns to IDLE without done
//   D     [7:0] in      : discrepancy from the BM datapath
//   berl_enable out     : datapath enable (0 in INIT loads initial values)
//   phase0      out     : first (discrepancy) cycle of an iteration
//   phase32     out     : last cycle of an iteration / rotation in DRAIN
//   count [5:0] out     : current iteration index
//   DI    [7:0] out     : GF(256) inverse of D (combinational)
//   busy        out     : high in every state except IDLE
//   done        out     : one-cycle completion pulse
//   out_valid   out     : coefficient stream qualifier during DRAIN
//   out_idx [4:0] out   : coefficient index during DRAIN
// ---------------------------------------------------------------------------
module rsdec_berl_ctrl
    import rsdec_pkg::*;
#(
    parameter int NSYN = NSYN_DEF,
    parameter int NPH  = NPH_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       syn_zero,
    input  logic       abort,
    input  logic [7:0] D,
    output logic       berl_enable,
    output logic       phase0,
    output logic       phase32,
    output logic [5:0] count,
    output logic [7:0] DI,
    output logic       busy,
    output logic       done,
    output logic       out_valid,
    output logic [4:0] out_idx
);

    // The phase counter is shared between the per-iteration position in CALC
    // and the coefficient index in DRAIN, so it must cover both ranges.
    localparam int PMAX = (NPH > NSYN) ? NPH : NSYN;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

    localparam logic [PW-1:0] P_LAST = PW'(NPH - 1);
    localparam logic [PW-1:0] D_LAST = PW'(NSYN - 1);
    localparam logic [5:0]    C_LAST = 6'(NSYN - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic [5:0]    cnt_q, cnt_d;
    logic          done_q;
    logic          take_start;

    rsdec_gf256_inv u_inv (
        .d  (D),
        .di (DI)
    );

    // Abort always wins over a coincident start.
    assign take_start = start && !abort;

    // State, phase and iteration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
        end
    end

    // done is registered off FIN, so it appears in the cycle after FIN
    // (the FSM is already back in IDLE). An abort in FIN suppresses it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == FIN) && !abort;
        end
    end

    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        cnt_d       = cnt_q;
        berl_enable = 1'b0;
        phase0      = 1'b0;
        phase32     = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;

        case (state_q)
            IDLE: begin
                busy  = 1'b0;
                p_d   = '0;
                cnt_d = '0;
                if (take_start) begin
`ifdef RSDEC_BERL_CTRL_ZERO_SKIP_EN
                    state_d = syn_zero ? FIN : INIT;
`else
                    state_d = INIT;
`endif
                end
            end

            // berl_enable stays low for this one cycle so the datapath loads
            // its initial polynomial values.
            INIT: begin
                state_d = CALC;
                p_d     = '0;
                cnt_d   = '0;
            end

            CALC: begin
                berl_enable = 1'b1;
                phase0      = (p_q == '0);
                phase32     = (p_q == P_LAST);
                if (p_q == P_LAST) begin
                    p_d = '0;
                    if (cnt_q == C_LAST) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end else begin
                    p_d = p_q + 1'b1;
                end
            end

            // Pure rotation of the coefficient registers: each cycle presents
            // the next coefficient at the datapath output.
            DRAIN: begin
                berl_enable = 1'b1;
                phase32     = 1'b1;
                out_valid   = 1'b1;
                if (p_q == D_LAST) begin
                    state_d = FIN;
                    p_d     = '0;
                end else begin
                    p_d = p_q + 1'b1;
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                p_d     = '0;
                cnt_d   = '0;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            p_d     = '0;
            cnt_d   = '0;
        end
    end

    assign count   = cnt_q;
    assign done    = done_q;
    assign out_idx = (state_q == DRAIN) ? 5'(p_q) : 5'd0;

`ifndef RSDEC_BERL_CTRL_ZERO_SKIP_EN
    // syn_zero has no function in this build.
    logic syn_zero_unused;
    assign syn_zero_unused = syn_zero;
`endif

endmodule

// File: tb/tb_rsdec_berl_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rsdec_berl_ctrl
// Bench for rsdec_berl_ctrl. The reference model tracks "cycles since the
// accepted start" and derives every output from that position on the decode
// timeline; GF(256) inverses come from a brute-force search over a
// carry-less multiply.
// ---------------------------------------------------------------------------
module tb_rsdec_berl_ctrl;

    localparam int NSYN     = 32;
    localparam int NPH      = 33;
    localparam int K_INIT   = 1;
    localparam int K_CALC0  = 2;
    localparam int K_CALCN  = K_CALC0 + NSYN * NPH - 1;
    localparam int K_DRAIN0 = K_CALCN + 1;
    localparam int K_FIN    = K_DRAIN0 + NSYN;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       syn_zero;
    logic       abort;
    logic [7:0] D;
    logic       berl_enable;
    logic       phase0;
    logic       phase32;
    logic [5:0] count;
    logic [7:0] DI;
    logic       busy;
    logic       done;
    logic       out_valid;
    logic [4:0] out_idx;

    int         n_checks = 0;
    int         n_fail   = 0;
    bit         cmp_en   = 0;
    logic [7:0] inv_tab [256];

    int         k        = 0;
    bit         done_exp = 0;

    rsdec_berl_ctrl #(
        .NSYN (NSYN),
        .NPH  (NPH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .syn_zero    (syn_zero),
        .abort       (abort),
        .D           (D),
        .berl_enable (berl_enable),
        .phase0      (phase0),
        .phase32     (phase32),
        .count       (count),
        .DI          (DI),
        .busy        (busy),
        .done        (done),
        .out_valid   (out_valid),
        .out_idx     (out_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Carry-less product reduced modulo 0x11D from the top bit down.
    function automatic logic [7:0] bmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'h0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) prod = prod ^ (16'(a) << i);
        end
        for (int i = 15; i >= 8; i--) begin
            if (prod[i]) prod = prod ^ (16'h011D << (i - 8));
        end
        return prod[7:0];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Output vector {busy, done, berl_enable, phase0, phase32, count, out_valid, out_idx}
    function automatic logic [16:0] dut_vec();
        return {busy, done, berl_enable, phase0, phase32, count, out_valid, out_idx};
    endfunction

    function automatic logic [16:0] model_vec(input int kk, input bit dn);
        logic       bsy, be, p0, p32, ov;
        logic [5:0] c;
        logic [4:0] ix;
        int         i;
        bsy = (kk >= K_INIT) && (kk <= K_FIN);
        be  = (kk >= K_CALC0) && (kk < K_FIN);
        p0  = 1'b0;
        p32 = 1'b0;
        ov  = 1'b0;
        c   = 6'd0;
        ix  = 5'd0;
        if (kk >= K_CALC0 && kk <= K_CALCN) begin
            i   = kk - K_CALC0;
            p0  = (i % NPH) == 0;
            p32 = (i % NPH) == NPH - 1;
            c   = 6'(i / NPH);
        end else if (kk >= K_DRAIN0 && kk < K_FIN) begin
            p32 = 1'b1;
            ov  = 1'b1;
            ix  = 5'(kk - K_DRAIN0);
        end
        return {bsy, dn, be, p0, p32, c, ov, ix};
    endfunction

    // Reference timeline: k = 0 idle, k = 1 INIT, then one step per cycle
    // until FIN; done follows FIN by one cycle.
    always @(posedge clk or negedge rst_n) begin : model
        int nk;
        bit nd;
        if (!rst_n) begin
            k        <= 0;
            done_exp <= 1'b0;
        end else begin
            nk = k;
            nd = 1'b0;
            if (k >= K_INIT && k <= K_FIN) begin
                if (abort) nk = 0;
                else if (k == K_FIN) begin
                    nk = 0;
                    nd = 1'b1;
                end else nk = k + 1;
            end else if (start && !abort) begin
`ifdef RSDEC_BERL_CTRL_ZERO_SKIP_EN
                nk = syn_zero ? K_FIN : K_INIT;
`else
                nk = K_INIT;
`endif
            end
            k        <= nk;
            done_exp <= nd;
        end
    end

    // Per-cycle compare. count is left unchecked while draining.
    initial begin : compare
        logic [16:0] m;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                m = (k >= K_DRAIN0 && k < K_FIN) ? 17'h1F03F : 17'h1FFFF;
                check("outputs", 32'(dut_vec() & m), 32'(model_vec(k, done_exp) & m));
                check("di_cycle", 32'(DI), 32'(inv_tab[D]));
            end
        end
    end

    task automatic run_decode(input bit sz, input int inj, input int ab, input int bound,
                              output int lat, output logic [1:0] after_ab);
        lat      = -1;
        after_ab = 2'b11;
        @(negedge clk);
        #1;
        start    = 1'b1;
        syn_zero = sz;
        abort    = 1'b0;
        D        = 8'($urandom);
        for (int n = 1; n <= bound; n++) begin
            @(negedge clk);
            if (done && lat < 0) lat = n;
            if (n == ab + 1) after_ab = {busy, berl_enable};
            #1;
            start    = 1'b0;
            abort    = 1'b0;
            syn_zero = 1'($urandom);
            D        = 8'($urandom);
            if (n == inj) start = 1'b1;
            if (n == ab) abort = 1'b1;
            if (lat >= 0 && n >= lat + 2) break;
        end
        start    = 1'b0;
        syn_zero = 1'b0;
    endtask

    initial begin : main
        int         lat;
        logic [1:0] ab_st;
        rst_n    = 1'b0;
        start    = 1'b0;
        syn_zero = 1'b0;
        abort    = 1'b0;
        D        = 8'h00;

        for (int a = 0; a < 256; a++) begin
            inv_tab[a] = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (bmul(8'(a), 8'(b)) == 8'h01) inv_tab[a] = 8'(b);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'(dut_vec()), 32'h0);
        @(negedge clk);
        #1;
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Inverse sweep over every D
        for (int d = 0; d < 256; d++) begin
            @(negedge clk);
            #1;
            D = 8'(d);
            #1;
            check("di_table", 32'(DI), 32'(inv_tab[d]));
            if (d != 0) check("d_times_di", 32'(bmul(D, DI)), 32'h1);
            if (d == 0) check("di_of_00", 32'(DI), 32'h00);
            if (d == 1) check("di_of_01", 32'(DI), 32'h01);
            if (d == 2) check("di_of_02", 32'(DI), 32'h8E);
        end

        // Full decode with a stray start during iteration 5
        run_decode(1'b0, K_CALC0 + 5 * NPH + 4, -1, 1300, lat, ab_st);
        check("done_latency_start_ignored", 32'(lat), 32'd1091);

        // Abort at iteration 10, phase 17
        run_decode(1'b0, -1, K_CALC0 + 10 * NPH + 17, 1200, lat, ab_st);
        check("abort_no_done", 32'(lat), 32'hFFFF_FFFF);
        check("abort_next_idle", 32'(ab_st), 32'h0);

        run_decode(1'b0, -1, -1, 1300, lat, ab_st);
        check("done_latency_after_abort", 32'(lat), 32'd1091);

        // Asynchronous reset in DRAIN at out_idx 12
        @(negedge clk);
        #1;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (K_DRAIN0 + 12 - 1) @(negedge clk);
        check("drain_idx12", 32'({out_valid, out_idx}), 32'h2C);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'(dut_vec()), 32'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("busy_after_reset", 32'(busy), 32'h0);

        run_decode(1'b0, -1, -1, 1300, lat, ab_st);
        check("done_latency_after_reset", 32'(lat), 32'd1091);

        // Start with all-zero syndromes
        run_decode(1'b1, -1, -1, 1300, lat, ab_st);
`ifdef RSDEC_BERL_CTRL_ZERO_SKIP_EN
        check("zero_skip_latency", 32'(lat), 32'd2);
`else
        check("zero_ignored_latency", 32'(lat), 32'd1091);
`endif

        // Random traffic: sparse starts, rare aborts, random syn_zero and D
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            #1;
            start    = ($urandom_range(0, 399) == 0);
            abort    = ($urandom_range(0, 2999) == 0);
            syn_zero = 1'($urandom);
            D        = 8'($urandom);
        end
        @(negedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rsdec_berl_ctrl.md
RSDEC_BERL_CTRL -- requirements
Module: rsdec_berl_ctrl

Interface
REQ-001 SHALL have parameter NSYN, default 32: syndrome count (2t) and number of BM iterations.
REQ-002 SHALL have parameter NPH, default 33: cycles per iteration (1 discrepancy cycle plus 32 shift cycles).
REQ-003 Port clk, input, 1: clock; all state on rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port start, input, 1: one-cycle request to decode the currently presented syndrome set.
REQ-006 Port syn_zero, input, 1: all syndromes zero; sampled with start.
REQ-007 Port abort, input, 1: synchronous cancel.
REQ-008 Port D, input, 8: discrepancy returned by the BM datapath.
REQ-009 Ports berl_enable, phase0 and phase32, output, 1 each: datapath sequencing controls.
REQ-010 Port count, output, 6: current iteration index.
REQ-011 Port DI, output, 8: GF(256) inverse of D.
REQ-012 Ports busy and done, output, 1 each: status; done is a one-cycle pulse.
REQ-013 Ports out_valid, output, 1, and out_idx, output, 5: coefficient stream qualifier and index.

Function
REQ-014 FSM states SHALL be IDLE, INIT, CALC, DRAIN and FIN.
REQ-015 IDLE: when start is sampled and busy=0, SHALL go to INIT; start while busy=1 SHALL be ignored with no queueing.
REQ-016 INIT lasts 1 cycle with berl_enable=0, which loads the datapath initial values; it SHALL then go to CALC with p=0 and count=0.
REQ-017 CALC: berl_enable=1, phase0=(p==0), phase32=(p==NPH-1); p SHALL increment 0..NPH-1 and then wrap to 0 with count+1.
REQ-018 count SHALL hold constant for a whole iteration; after count=NSYN-1 and p=NPH-1 the FSM SHALL go to DRAIN, for 1056 CALC cycles total at defaults.
REQ-019 DRAIN: berl_enable=1, phase0=0, phase32=1 (pure rotation); out_valid=1 for exactly NSYN cycles with out_idx 0..31 ascending; then go to FIN.
REQ-020 FIN: done=1 for 1 cycle, then IDLE.
REQ-021 busy SHALL be 1 in INIT, CALC, DRAIN and FIN, and 0 only in IDLE.
REQ-022 DI = inv(D) SHALL be combinational, with inv(0)=0; D*DI=1 for every nonzero D.
REQ-023 abort in any non-IDLE state SHALL force IDLE on the next edge: berl_enable=0, out_valid=0, no done; abort in IDLE has no effect.
REQ-024 If abort and start coincide, abort SHALL win, and start is dropped.
REQ-025 Outside CALC and DRAIN, phase0=phase32=0 and count=0.

Reset
REQ-026 While rst_n=0: state=IDLE, p=0, count=0, berl_enable=0, phase0=0, phase32=0, busy=0, done=0, out_valid=0, out_idx=0.
REQ-027 Reset asserted mid-operation SHALL abandon the decode immediately with no done pulse; the first start after release SHALL begin a fresh decode.

Configuration
REQ-028 Macro RSDEC_BERL_CTRL_ZERO_SKIP_EN defined: start with syn_zero=1 SHALL go IDLE->FIN directly, giving done 2 cycles after start and no INIT/CALC/DRAIN or out_valid.
REQ-029 Macro undefined: syn_zero SHALL be ignored, and every start runs the full sequence.

Structure
REQ-030 A shared package rsdec_pkg SHALL hold the FSM state enum, the NSYN/NPH defaults and the GF(256) field polynomial constant (0x11D).
REQ-031 One sub-module, rsdec_gf256_inv (8-bit combinational inverse lookup), SHALL produce DI.

Verification
REQ-032 Reset then start, syn_zero=0 -> INIT 1 cycle; phase0 at CALC cycles 0,33,...,1023; count 0..31; out_valid 32 cycles; done at cycle 1091 after start.
REQ-033 Sweep D over 0x00..0xFF -> DI(0x00)=0x00, DI(0x01)=0x01, DI(0x02)=0x8E; D*DI=1 for all D!=0.
REQ-034 start again at CALC count=5 -> ignored; sequence and done timing unchanged.
REQ-035 abort at CALC count=10, p=17 -> next cycle IDLE, berl_enable=0, no done; a following start decodes normally.
REQ-036 rst_n low during DRAIN out_idx=12 -> all outputs 0 asynchronously; after release, busy=0.
REQ-037 With RSDEC_BERL_CTRL_ZERO_SKIP_EN and start with syn_zero=1 -> done 2 cycles later, out_valid never 1; without the macro -> full 1091-cycle sequence.
